// File: rtl/btn_debouncer_bank.sv
// btn_debouncer_bank: bank of CHANNELS independent push-button debouncers.
// Each channel has a SYNC_STAGES-flop synchroniser feeding a four-state
// lockout FSM. It produces a debounced level plus one-cycle press and
// release ticks.
// Optional long-press tick: define LONG_PRESS_EN to build the per-channel
// hold counters. Without the macro, hold is tied low.
// The release tick port is called release_tick because `release` is a
// reserved word in SystemVerilog.
module btn_debouncer_bank #(
  parameter int CHANNELS    = 4,
  parameter int DB_CYCLES   = 10,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] hold
);

  localparam int CNT_W = $clog2(DB_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCK_HI = 2'd1,
    ST_HELD    = 2'd2,
    ST_LOCK_LO = 2'd3
  } state_t;

  // Reject parameter sets that would break the lockout or hold timing.
  if (CHANNELS < 1 || DB_CYCLES < 2 || SYNC_STAGES < 2 || HOLD_CYCLES <= DB_CYCLES) begin : g_param_check
    $error("btn_debouncer_bank: invalid parameter set");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    state_t                 state_r;
    logic                   press_r;
    logic                   release_r;
    logic                   level_r;
    logic                   s_s;
    logic                   go_press_s;
    logic                   go_release_s;
    logic                   cnt_done_s;

    assign s_s          = sync_r[SYNC_STAGES-1];
    assign go_press_s   = (state_r == ST_IDLE) && s_s;
    assign go_release_s = (state_r == ST_HELD) && !s_s;
    assign cnt_done_s   = (cnt_r == CNT_W'(DB_CYCLES - 1));

    // Shift the raw button through the synchroniser chain.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], btn[i]};
      end
    end

    // Lockout FSM: accept an edge, then ignore the input for DB_CYCLES clocks.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r   <= ST_IDLE;
        cnt_r     <= {CNT_W{1'b0}};
        press_r   <= 1'b0;
        release_r <= 1'b0;
        level_r   <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        case (state_r)
          ST_IDLE: begin
            if (go_press_s) begin
              press_r <= 1'b1;
              level_r <= 1'b1;
              cnt_r   <= {CNT_W{1'b0}};
              state_r <= ST_LOCK_HI;
            end
          end
          ST_LOCK_HI: begin
            if (cnt_done_s) begin
              state_r <= ST_HELD;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          ST_HELD: begin
            if (go_release_s) begin
              release_r <= 1'b1;
              level_r   <= 1'b0;
              cnt_r     <= {CNT_W{1'b0}};
              state_r   <= ST_LOCK_LO;
            end
          end
          ST_LOCK_LO: begin
            if (cnt_done_s) begin
              state_r <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
          end
        endcase
      end
    end

    assign press[i]        = press_r;
    assign release_tick[i] = release_r;
    assign level[i]        = level_r;

`ifdef LONG_PRESS_EN
    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
    logic [HCNT_W-1:0] hcnt_r;
    logic              hold_r;

    // Count clocks since the press tick; fire hold once at HOLD_CYCLES, then saturate.
    always_ff @(posedge clk) begin
      if (rst) begin
        hcnt_r <= {HCNT_W{1'b0}};
        hold_r <= 1'b0;
      end else begin
        hold_r <= 1'b0;
        if (go_press_s || go_release_s || !level_r) begin
          hcnt_r <= {HCNT_W{1'b0}};
        end else if (hcnt_r != HCNT_W'(HOLD_CYCLES)) begin
          hcnt_r <= hcnt_r + HCNT_W'(1);
          if (hcnt_r == HCNT_W'(HOLD_CYCLES - 1)) begin
            hold_r <= 1'b1;
          end
        end
      end
    end

    assign hold[i] = hold_r;
`else
    assign hold[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_debouncer_bank.sv
// Directed testbench for btn_debouncer_bank (CHANNELS=4, DB_CYCLES=10,
// SYNC_STAGES=2, HOLD_CYCLES=50). Inputs change and outputs are sampled
// on the falling clock edge.
module tb_btn_debouncer_bank;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] press;
  logic [3:0] release_tick;
  logic [3:0] level;
  logic [3:0] hold;

  int tests;
  int failed;

  btn_debouncer_bank #(
    .CHANNELS(4),
    .DB_CYCLES(10),
    .SYNC_STAGES(2),
    .HOLD_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .press(press),
    .release_tick(release_tick),
    .level(level),
    .hold(hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] acc;
    logic [3:0] acc_rel;
    int         npress;
    int         nrel;
    int         nhold;
    int         hold_at;

    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    btn    = 4'b0000;
    @(negedge clk);
    step(3);
    check("reset_outputs", 32'({press, release_tick, level, hold}), 32'(16'h0000));
    rst = 1'b0;

    // Idle for 50 cycles: nothing may move.
    acc = 4'b0000;
    for (int k = 0; k < 50; k++) begin
      step(1);
      acc = acc | press | release_tick | level | hold;
    end
    check("idle_50", 32'(acc), 32'(4'b0000));

    // Clean press on ch0: press tick after the 3rd edge.
    btn = 4'b0001;
    step(2);
    check("ch0_press_early", 32'(press), 32'(4'b0000));
    step(1);
    check("ch0_press_tick", 32'(press), 32'(4'b0001));
    check("ch0_level_up", 32'(level), 32'(4'b0001));
    step(1);
    check("ch0_press_single", 32'(press), 32'(4'b0000));
    step(1);
    // Now after edge P+2; button drops, first sampled at P+3.
    btn = 4'b0000;
    acc = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      step(1);
      acc = acc | release_tick;
    end
    check("ch0_no_early_release", 32'(acc), 32'(4'b0000));
    check("ch0_level_locked", 32'(level), 32'(4'b0001));
    step(1);
    check("ch0_release_P11", 32'(release_tick), 32'(4'b0001));
    check("ch0_level_down", 32'(level), 32'(4'b0000));

    // Re-press right after the release: held off until LOCK_LO finishes.
    btn = 4'b0001;
    acc = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      step(1);
      acc = acc | press;
    end
    check("ch0_repress_locked", 32'(acc), 32'(4'b0000));
    step(1);
    check("ch0_repress_tick", 32'(press), 32'(4'b0001));
    btn = 4'b0000;
    acc_rel = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      step(1);
      acc_rel = acc_rel | release_tick;
    end
    check("ch0_second_release", 32'(acc_rel), 32'(4'b0001));
    check("ch0_level_final", 32'(level), 32'(4'b0000));
    step(12);

    // Bouncing ch1 for 8 cycles, then steady high.
    npress = 0;
    nrel   = 0;
    for (int k = 0; k < 8; k++) begin
      btn[1] = (k % 2 == 0);
      step(1);
      npress += int'(press[1]);
      nrel   += int'(release_tick[1]);
    end
    btn[1] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step(1);
      npress += int'(press[1]);
      nrel   += int'(release_tick[1]);
    end
    check("bounce_press_count", 32'(npress), 32'(1));
    check("bounce_release_count", 32'(nrel), 32'(0));
    check("bounce_level", 32'(level), 32'(4'b0010));
    btn[1] = 1'b0;
    nrel = 0;
    for (int k = 0; k < 15; k++) begin
      step(1);
      nrel += int'(release_tick[1]);
    end
    check("bounce_release_once", 32'(nrel), 32'(1));
    check("bounce_level_down", 32'(level), 32'(4'b0000));
    step(12);

    // All four channels pressed together.
    btn = 4'b1111;
    step(2);
    check("all_press_early", 32'(press), 32'(4'b0000));
    step(1);
    check("all_press_tick", 32'(press), 32'(4'b1111));
    step(1);
    check("all_press_single", 32'(press), 32'(4'b0000));
    btn = 4'b0000;
    step(9);
    check("all_release_early", 32'(release_tick), 32'(4'b0000));
    step(1);
    check("all_release_tick", 32'(release_tick), 32'(4'b1111));
    check("all_level_down", 32'(level), 32'(4'b0000));
    step(12);

    // Reset in the middle of LOCK_HI, with the button held through reset.
    btn = 4'b0100;
    step(3);
    check("rst_mid_press", 32'(press), 32'(4'b0100));
    step(2);
    rst = 1'b1;
    step(1);
    check("rst_mid_level", 32'(level), 32'(4'b0000));
    check("rst_mid_all", 32'({press, release_tick, level, hold}), 32'(16'h0000));
    rst = 1'b0;
    step(2);
    check("rst_held_early", 32'(press), 32'(4'b0000));
    step(1);
    check("rst_held_press", 32'(press), 32'(4'b0100));
    btn = 4'b0000;
    step(25);

`ifdef LONG_PRESS_EN
    // Long press on ch2: a single hold tick exactly HOLD_CYCLES after press.
    btn = 4'b0100;
    step(3);
    check("hold_press", 32'(press), 32'(4'b0100));
    nhold   = 0;
    hold_at = 0;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (hold != 4'b0000) begin
        nhold++;
        hold_at = k;
      end
    end
    check("hold_count", 32'(nhold), 32'(1));
    check("hold_at_P50", 32'(hold_at), 32'(50));
    btn = 4'b0000;
    step(25);
    btn = 4'b0100;
    step(3);
    acc = 4'b0000;
    for (int k = 0; k < 27; k++) begin
      step(1);
      acc = acc | hold;
    end
    btn = 4'b0000;
    step(3);
    check("short_release_P30", 32'(release_tick), 32'(4'b0100));
    for (int k = 0; k < 40; k++) begin
      step(1);
      acc = acc | hold;
    end
    check("short_no_hold", 32'(acc), 32'(4'b0000));
`else
    // Without the long-press feature hold never moves, however long the press.
    btn = 4'b0100;
    acc = 4'b0000;
    for (int k = 0; k < 60; k++) begin
      step(1);
      acc = acc | hold;
    end
    check("hold_tied_low", 32'(acc), 32'(4'b0000));
    check("hold_level", 32'(level), 32'(4'b0100));
    btn = 4'b0000;
    step(25);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
